// File: rtl/mul32_shift_add_pkg.sv
// Shared constants and state encoding for the iterative shift-add multiplier.
// Imported by the interface and the top-level datapath.
package mul32_shift_add_pkg;

    localparam int WIDTH = 32;
    localparam logic [5:0] ITER_LAST = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mul32_shift_add_pkg

// File: rtl/mul32_shift_add_if.sv
// Request/response bundle between an issuing datapath (master) and the multiplier (slave).
interface mul32_shift_add_if;
    import mul32_shift_add_pkg::*;

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface : mul32_shift_add_if

// File: rtl/mul32_shift_add_adder.sv
// 32-bit adder assembled from four 8-bit carry-lookahead blocks.
// Carries lookahead inside each byte and ripple between bytes.
module Adder_LookAhead8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic [7:0] p_s;
    logic [7:0] g_s;
    logic [8:0] c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Flattened lookahead: each carry is a sum of generate terms gated by the propagates above them.
    always_comb begin
        logic prop_v;
        c_s    = 9'd0;
        prop_v = 1'b0;
        c_s[0] = ci;
        for (int i = 0; i < 8; i++) begin
            c_s[i+1] = g_s[i];
            prop_v   = p_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                c_s[i+1] = c_s[i+1] | (prop_v & g_s[j]);
                prop_v   = prop_v & p_s[j];
            end
            c_s[i+1] = c_s[i+1] | (prop_v & ci);
        end
    end

    assign s  = p_s ^ c_s[7:0];
    assign co = c_s[8];

endmodule : Adder_LookAhead8

module Adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [4:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_byte
        Adder_LookAhead8 u_la8 (
            .a  (a[8*i +: 8]),
            .b  (b[8*i +: 8]),
            .ci (c_s[i]),
            .s  (s[8*i +: 8]),
            .co (c_s[i+1])
        );
    end

    assign co = c_s[4];

endmodule : Adder

// File: rtl/mul32_shift_add.sv
// Iterative unsigned 32x32->64 multiplier: one shared Adder, one product bit per cycle,
// 32 iterations per operation with a start/busy/done handshake.
module mul32_shift_add
    import mul32_shift_add_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mul32_shift_add_if.slave   bus
);

    state_t              state_r,   state_next;
    logic [WIDTH-1:0]    mcand_r,   mcand_next;
    logic [WIDTH-1:0]    acc_hi_r,  acc_hi_next;
    logic [WIDTH-1:0]    acc_lo_r,  acc_lo_next;
    logic [5:0]          cnt_r,     cnt_next;
    logic [2*WIDTH-1:0]  product_r, product_next;
    logic                busy_r,    busy_next;
    logic                done_r,    done_next;

    logic [WIDTH-1:0]    add_b_s;
    logic [WIDTH-1:0]    sum_s;
    logic                co_s;
    logic [2*WIDTH-1:0]  shifted_s;

    assign add_b_s = acc_lo_r[0] ? mcand_r : 32'd0;

    Adder u_adder (
        .a  (acc_hi_r),
        .b  (add_b_s),
        .ci (1'b0),
        .s  (sum_s),
        .co (co_s)
    );

    // Carry-out becomes the new top bit, so the 64-bit result never overflows.
    assign shifted_s = {co_s, sum_s, acc_lo_r[WIDTH-1:1]};

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_next   = state_r;
        mcand_next   = mcand_r;
        acc_hi_next  = acc_hi_r;
        acc_lo_next  = acc_lo_r;
        cnt_next     = cnt_r;
        product_next = product_r;

        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    mcand_next  = bus.a;
                    acc_lo_next = bus.b;
                    acc_hi_next = 32'd0;
                    cnt_next    = 6'd0;
                    state_next  = CALC;
                end else begin
                    state_next  = IDLE;
                end
            end
            CALC: begin
                acc_hi_next = shifted_s[2*WIDTH-1:WIDTH];
                acc_lo_next = shifted_s[WIDTH-1:0];
                cnt_next    = cnt_r + 6'd1;
                if (cnt_r == ITER_LAST) begin
                    product_next = shifted_s;
                    state_next   = DONE;
                end else begin
                    state_next   = CALC;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == CALC);
        done_next = (state_next == DONE);
    end

    // State, datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mcand_r   <= 32'd0;
            acc_hi_r  <= 32'd0;
            acc_lo_r  <= 32'd0;
            cnt_r     <= 6'd0;
            product_r <= 64'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next;
            mcand_r   <= mcand_next;
            acc_hi_r  <= acc_hi_next;
            acc_lo_r  <= acc_lo_next;
            cnt_r     <= cnt_next;
            product_r <= product_next;
            busy_r    <= busy_next;
            done_r    <= done_next;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

endmodule : mul32_shift_add

// File: tb/tb_mul32_shift_add.sv
// Self-checking bench for mul32_shift_add: vector table, handshake corner cases and
// random operands, with a scoreboard matched against each done pulse.
module tb_mul32_shift_add;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul32_shift_add_if bus ();

    mul32_shift_add dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] exp;
        int          acc;
    } sb_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    // Edge counter used to measure start-to-done latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (bus.busy && bus.done) begin
                failures++;
                $display("FAIL busy_done_overlap cycle=%0d actual busy=1 done=1 required not both", cyc);
            end
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done cycle=%0d actual done=1 required done=0", cyc);
                end else begin
                    e = sb_q.pop_front();
                    checks += 2;
                    if (bus.product !== e.exp) begin
                        failures++;
                        $display("FAIL product actual=%h required=%h", bus.product, e.exp);
                    end
                    if (cyc != e.acc + 32) begin
                        failures++;
                        $display("FAIL latency actual_cycle=%0d required_cycle=%0d", cyc, e.acc + 32);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sb_q.push_back('{exp, cyc + 1});
        tick();
        bus.start = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual_pending=%0d required_pending=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   acc1;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,          32'hDEAD_BEEF,  64'h0000_0000_0000_0000};
        vecs[3] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
        vecs[4] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[6] = '{32'h0001_0001,  32'h0000_FFFF,  64'h0000_0000_FFFF_FFFF};

        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        rst_n     = 1'b0;
        repeat (3) tick();
        check64("reset_busy",    {63'd0, bus.busy}, 64'd0);
        check64("reset_done",    {63'd0, bus.done}, 64'd0);
        check64("reset_product", bus.product,       64'd0);
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].exp);
            check64("busy_after_start", {63'd0, bus.busy}, 64'd1);
            check64("done_after_start", {63'd0, bus.done}, 64'd0);
            drain(40);
            repeat (2) tick();
            check64("busy_idle",    {63'd0, bus.busy}, 64'd0);
            check64("product_hold", bus.product,       vecs[i].exp);
        end

        // Start while busy is ignored.
        issue(32'd7, 32'd6, 64'd42);
        repeat (9) tick();
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drain(40);
        repeat (40) tick();
        check64("ignored_start_product", bus.product, 64'd42);

        // Asynchronous reset mid-operation.
        issue(32'd100, 32'd200, 64'd20000);
        repeat (13) tick();
        #2 rst_n = 1'b0;
        #1;
        check64("midreset_busy",    {63'd0, bus.busy}, 64'd0);
        check64("midreset_done",    {63'd0, bus.done}, 64'd0);
        check64("midreset_product", bus.product,       64'd0);
        sb_q.delete();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        issue(32'd2, 32'd2, 64'd4);
        drain(40);
        repeat (40) tick();
        check64("post_reset_product", bus.product, 64'd4);

        // Back-to-back issue with start held through done.
        bus.a     = 32'h0001_0000;
        bus.b     = 32'h0001_0000;
        bus.start = 1'b1;
        acc1      = cyc + 1;
        sb_q.push_back('{64'h0000_0001_0000_0000, acc1});
        tick();
        bus.a     = 32'd12;
        bus.b     = 32'd12;
        sb_q.push_back('{64'd144, acc1 + 33});
        while (cyc < acc1 + 33) tick();
        bus.start = 1'b0;
        drain(80);
        repeat (2) tick();
        check64("b2b_final_product", bus.product, 64'd144);

        // Random operands against a 64-bit reference product.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0:       ra = 32'hFFFF_FFFF;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'd0;
                default: ra = ra;
            endcase
            issue(ra, rb, {32'd0, ra} * {32'd0, rb});
            drain(40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mul32_shift_add
